// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined block carry-lookahead adder/subtractor with valid/ready handshaking.
// Optional signed-overflow output enabled by defining CLA_ADDER_PIPE_OVF_EN.
module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NGRP = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || GROUP < 2 || GROUP > 8) begin : g_param_check
    $error("cla_adder_pipe: WIDTH must be a multiple of GROUP and GROUP must be 2..8");
  end

  logic vld_p1_q, vld_p1_d;
  logic vld_p2_q, vld_p2_d;
  logic out_adv, accept, adv_p1;

  always_comb begin
    out_adv  = ~vld_p2_q | out_ready;
    in_ready = ~vld_p1_q | out_adv;
    accept   = in_valid & in_ready;
    adv_p1   = vld_p1_q & out_adv;
    vld_p1_d = accept | (vld_p1_q & ~out_adv);
    vld_p2_d = out_adv ? vld_p1_q : vld_p2_q;
  end

  // Stage 0 -> 1: bit propagate/generate and per-group lookahead terms
  logic [WIDTH-1:0] b_x_p0, p_p0, g_p0;
  logic [NGRP-1:0]  gp_p0, gg_p0;
  logic             c0_p0;

  logic [WIDTH-1:0] p_p1_q, p_p1_d, g_p1_q, g_p1_d;
  logic [NGRP-1:0]  gp_p1_q, gp_p1_d, gg_p1_q, gg_p1_d;
  logic             c0_p1_q, c0_p1_d;

  always_comb begin
    b_x_p0 = in_b ^ {WIDTH{in_sub}};
    c0_p0  = in_sub | in_cin;
    p_p0   = in_a ^ b_x_p0;
    g_p0   = in_a & b_x_p0;
    gp_p0  = '1;
    gg_p0  = '0;
    for (int k = 0; k < NGRP; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        gp_p0[k] = gp_p0[k] & p_p0[k*GROUP+j];
        gg_p0[k] = g_p0[k*GROUP+j] | (p_p0[k*GROUP+j] & gg_p0[k]);
      end
    end
  end

  always_comb begin
    p_p1_d  = accept ? p_p0  : p_p1_q;
    g_p1_d  = accept ? g_p0  : g_p1_q;
    gp_p1_d = accept ? gp_p0 : gp_p1_q;
    gg_p1_d = accept ? gg_p0 : gg_p1_q;
    c0_p1_d = accept ? c0_p0 : c0_p1_q;
  end

  always_ff @(posedge clk) begin
    p_p1_q  <= p_p1_d;
    g_p1_q  <= g_p1_d;
    gp_p1_q <= gp_p1_d;
    gg_p1_q <= gg_p1_d;
    c0_p1_q <= c0_p1_d;
  end

  // Stage 1 -> 2: group carry chain, intra-group lookahead carries, sum
  logic [NGRP:0]    gc_p1;
  logic [WIDTH:0]   c_p1;
  logic             gacc_p1, pacc_p1;
  logic [WIDTH-1:0] sum_p2_q, sum_p2_d;
  logic             cout_p2_q, cout_p2_d;

  always_comb begin
    gc_p1   = '0;
    c_p1    = '0;
    gacc_p1 = 1'b0;
    pacc_p1 = 1'b1;
    gc_p1[0] = c0_p1_q;
    for (int k = 0; k < NGRP; k++) begin
      gc_p1[k+1] = gg_p1_q[k] | (gp_p1_q[k] & gc_p1[k]);
    end
    for (int k = 0; k < NGRP; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        gacc_p1 = 1'b0;
        pacc_p1 = 1'b1;
        for (int i = 0; i < j; i++) begin
          gacc_p1 = g_p1_q[k*GROUP+i] | (p_p1_q[k*GROUP+i] & gacc_p1);
          pacc_p1 = pacc_p1 & p_p1_q[k*GROUP+i];
        end
        c_p1[k*GROUP+j] = gacc_p1 | (pacc_p1 & gc_p1[k]);
      end
    end
    c_p1[WIDTH] = gc_p1[NGRP];
    sum_p2_d  = adv_p1 ? (p_p1_q ^ c_p1[WIDTH-1:0]) : sum_p2_q;
    cout_p2_d = adv_p1 ? c_p1[WIDTH] : cout_p2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      sum_p2_q  <= '0;
      cout_p2_q <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      sum_p2_q  <= sum_p2_d;
      cout_p2_q <= cout_p2_d;
    end
  end

`ifdef CLA_ADDER_PIPE_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it
  logic ovf_p2_q, ovf_p2_d;

  always_comb begin
    ovf_p2_d = adv_p1 ? (c_p1[WIDTH-1] ^ c_p1[WIDTH]) : ovf_p2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_p2_q <= 1'b0;
    else        ovf_p2_q <= ovf_p2_d;
  end

  assign out_ovf = ovf_p2_q;
`else
  assign out_ovf = 1'b0;
`endif

  assign out_valid = vld_p2_q;
  assign out_sum   = sum_p2_q;
  assign out_cout  = cout_p2_q;

endmodule
